ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_pkg.sv | 27 ++
 rtl/ex_if.sv | 25 ++
 rtl/ex_alu.sv | 71 +++++++
 rtl/ex_stage.sv | 57 +++++
 tb/tb_ex_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage (ALU ops, shift ops, branch conditions, operand-B sources)
package ex_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;
  localparam logic [2:0] COND_NONE = 3'd0;
  localparam logic [2:0] COND_EQ   = 3'd1;
  localparam logic [2:0] COND_NE   = 3'd2;
  localparam logic [2:0] COND_LTZ  = 3'd3;
  localparam logic [2:0] COND_GEZ  = 3'd4;
  localparam logic [2:0] COND_GTZ  = 3'd5;
  localparam logic [2:0] COND_LEZ  = 3'd6;
  localparam logic [2:0] SRCB_REG  = 3'd0;
  localparam logic [2:0] SRCB_SEXT = 3'd1;
  localparam logic [2:0] SRCB_ZEXT = 3'd2;
  localparam logic [2:0] SRCB_LUI  = 3'd3;
  localparam logic [2:0] SRCB_ZERO = 3'd4;
endpackage

// File: rtl/ex_if.sv
// ex_if: ID/EX slot inputs and EX/MEM latch plus redirect outputs of the execute stage
interface ex_if;
  logic [4:0]  Rs_in, Rt_in, Rd_in;
  logic [31:0] A_in, B_in, offset_in, pc4_in;
  logic        RegDst_in, Shift_amountSrc_in, Jump_in, ALUShift_Sel_in, RegDt0_in;
  logic [3:0]  ALU_op_in;
  logic [1:0]  Shift_op_in;
  logic [2:0]  ALUSrcB_in, Condition_in;
  logic        valid_in, stall_in;
  logic [31:0] res_out, wdata_out, target;
  logic [4:0]  wreg_out;
  logic        wen_out, valid_out, redirect, flush_out, ovf_out;
  modport master (
    output Rs_in, Rt_in, Rd_in, A_in, B_in, offset_in, pc4_in, RegDst_in, Shift_amountSrc_in,
           Jump_in, ALUShift_Sel_in, RegDt0_in, ALU_op_in, Shift_op_in, ALUSrcB_in, Condition_in,
           valid_in, stall_in,
    input  res_out, wdata_out, wreg_out, wen_out, valid_out, redirect, target, flush_out, ovf_out
  );
  modport slave (
    input  Rs_in, Rt_in, Rd_in, A_in, B_in, offset_in, pc4_in, RegDst_in, Shift_amountSrc_in,
           Jump_in, ALUShift_Sel_in, RegDt0_in, ALU_op_in, Shift_op_in, ALUSrcB_in, Condition_in,
           valid_in, stall_in,
    output res_out, wdata_out, wreg_out, wen_out, valid_out, redirect, target, flush_out, ovf_out
  );
endinterface

// File: rtl/ex_alu.sv
// ex_alu: operand-B mux, ALU, shifter and branch condition; overflow detect only with EX_OVERFLOW_TRAP_EN
module ex_alu
  import ex_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_offset,
  input  logic [3:0]  i_alu_op,
  input  logic [1:0]  i_shift_op,
  input  logic [2:0]  i_srcb,
  input  logic [2:0]  i_cond,
  input  logic        i_shamt_src,
  input  logic        i_shift_sel,
  output logic [31:0] o_result,
  output logic        o_taken,
  output logic        o_ovf
);
  logic [31:0] w_opb, w_sum, w_diff, w_alu, w_shift, w_ror;
  logic [4:0]  w_sh;
  assign w_opb = (i_srcb == SRCB_SEXT) ? i_offset :
                 (i_srcb == SRCB_ZEXT) ? {16'h0, i_offset[15:0]} :
                 (i_srcb == SRCB_LUI)  ? {i_offset[15:0], 16'h0} :
                 (i_srcb == SRCB_ZERO) ? 32'd0 : i_b;
  assign w_sum  = i_a + w_opb;
  assign w_diff = i_a - w_opb;
  assign w_sh   = i_shamt_src ? i_a[4:0] : i_offset[10:6];
  assign w_ror  = 32'({i_b, i_b} >> w_sh);
  // ALU operation select; undefined opcodes yield zero
  always_comb begin
    case (i_alu_op)
      ALU_ADD:  w_alu = w_sum;
      ALU_SUB:  w_alu = w_diff;
      ALU_AND:  w_alu = i_a & w_opb;
      ALU_OR:   w_alu = i_a | w_opb;
      ALU_XOR:  w_alu = i_a ^ w_opb;
      ALU_NOR:  w_alu = ~(i_a | w_opb);
      ALU_SLT:  w_alu = {31'd0, $signed(i_a) < $signed(w_opb)};
      ALU_SLTU: w_alu = {31'd0, i_a < w_opb};
      default:  w_alu = 32'd0;
    endcase
  end
  // shifter always works on the raw B operand
  always_comb begin
    case (i_shift_op)
      SH_SLL:  w_shift = i_b << w_sh;
      SH_SRL:  w_shift = i_b >> w_sh;
      SH_SRA:  w_shift = $signed(i_b) >>> w_sh;
      default: w_shift = w_ror;
    endcase
  end
  // signed branch condition on A (and B for the equality tests)
  always_comb begin
    case (i_cond)
      COND_EQ:  o_taken = i_a == i_b;
      COND_NE:  o_taken = i_a != i_b;
      COND_LTZ: o_taken = $signed(i_a) < 0;
      COND_GEZ: o_taken = $signed(i_a) >= 0;
      COND_GTZ: o_taken = $signed(i_a) > 0;
      COND_LEZ: o_taken = $signed(i_a) <= 0;
      default:  o_taken = 1'b0;
    endcase
  end
  assign o_result = i_shift_sel ? w_shift : w_alu;
`ifdef EX_OVERFLOW_TRAP_EN
  assign o_ovf = !i_shift_sel &&
                 ((i_alu_op == ALU_ADD && i_a[31] == w_opb[31] && w_sum[31] != i_a[31]) ||
                  (i_alu_op == ALU_SUB && i_a[31] != w_opb[31] && w_diff[31] != i_a[31]));
`else
  assign o_ovf = 1'b0;
`endif
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with EX/MEM latch and branch/jump redirect; optional EX_OVERFLOW_TRAP_EN traps signed ADD/SUB overflow
module ex_stage
  import ex_pkg::*;
(
  input logic clk,
  input logic rst,
  ex_if.slave x
);
  logic [31:0] w_result, r_res, r_wdata;
  logic [4:0]  w_wreg, r_wreg;
  logic        w_taken, w_ovf, w_wen, w_go, r_wen, r_valid, r_ovf;
  logic        w_unused;
  ex_alu u_alu (
    .i_a(x.A_in), .i_b(x.B_in), .i_offset(x.offset_in), .i_alu_op(x.ALU_op_in),
    .i_shift_op(x.Shift_op_in), .i_srcb(x.ALUSrcB_in), .i_cond(x.Condition_in),
    .i_shamt_src(x.Shift_amountSrc_in), .i_shift_sel(x.ALUShift_Sel_in),
    .o_result(w_result), .o_taken(w_taken), .o_ovf(w_ovf)
  );
  assign w_unused = ^{x.Rs_in, w_ovf};
  assign w_wreg = x.RegDst_in ? x.Rd_in : x.Rt_in;
  assign w_wen  = (w_wreg != 5'd0) &&
                  (x.RegDt0_in ? (x.B_in == 32'd0) : (x.Condition_in == COND_NONE && !x.Jump_in));
  assign w_go   = x.valid_in && !x.stall_in && !rst;
  assign x.redirect  = w_go && (x.Jump_in || w_taken);
  assign x.flush_out = x.redirect;
  assign x.target    = x.Jump_in ? {x.pc4_in[31:28], x.offset_in[25:0], 2'b00}
                                 : x.pc4_in + {x.offset_in[29:0], 2'b00};
  // EX/MEM latch: reset beats stall, stall holds, bubbles never write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res   <= '0;
      r_wdata <= '0;
      r_wreg  <= '0;
      r_wen   <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (!x.stall_in) begin
      r_res   <= w_result;
      r_wdata <= x.B_in;
      r_wreg  <= w_wreg;
`ifdef EX_OVERFLOW_TRAP_EN
      r_wen   <= x.valid_in && w_wen && !w_ovf;
      r_ovf   <= x.valid_in && w_ovf;
`else
      r_wen   <= x.valid_in && w_wen;
      r_ovf   <= 1'b0;
`endif
      r_valid <= x.valid_in;
    end
  end
  assign x.res_out   = r_res;
  assign x.wdata_out = r_wdata;
  assign x.wreg_out  = r_wreg;
  assign x.wen_out   = r_wen;
  assign x.valid_out = r_valid;
  assign x.ovf_out   = r_ovf;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage; expectations from an independent reference model
module tb_ex_stage;
  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, off, pc4;
    logic        regdst, shsrc, jump, shsel, dt0;
    logic [3:0]  aop;
    logic [1:0]  sop;
    logic [2:0]  srcb, cond;
    logic        valid, stall;
  } stim_t;
  typedef struct packed {
    logic [31:0] res, wdata;
    logic [4:0]  wreg;
    logic        wen, valid, ovf;
  } lat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  lat_t sb[$];
  lat_t last = '0;

  ex_if bus ();
  ex_stage dut (.clk(clk), .rst(rst), .x(bus));

  always #5 clk = ~clk;

  function automatic lat_t f_model(input stim_t s);
    logic [31:0] opb, alu, shv;
    logic [32:0] wide;
    logic [4:0]  sh, wreg;
    logic        ov, wen;
    lat_t        r;
    case (s.srcb)
      3'd1: opb = s.off;
      3'd2: opb = {16'h0, s.off[15:0]};
      3'd3: opb = {s.off[15:0], 16'h0};
      3'd4: opb = 32'd0;
      default: opb = s.b;
    endcase
    ov = 1'b0;
    wide = '0;
    case (s.aop)
      4'd0: begin wide = {s.a[31], s.a} + {opb[31], opb}; alu = wide[31:0]; ov = wide[32] ^ wide[31]; end
      4'd1: begin wide = {s.a[31], s.a} - {opb[31], opb}; alu = wide[31:0]; ov = wide[32] ^ wide[31]; end
      4'd2: alu = s.a & opb;
      4'd3: alu = s.a | opb;
      4'd4: alu = s.a ^ opb;
      4'd5: alu = ~(s.a | opb);
      4'd6: alu = (s.a[31] != opb[31]) ? {31'd0, s.a[31]} : {31'd0, s.a < opb};
      4'd7: alu = {31'd0, s.a < opb};
      default: alu = 32'd0;
    endcase
    sh = s.shsrc ? s.a[4:0] : s.off[10:6];
    case (s.sop)
      2'd0: shv = s.b << sh;
      2'd1: shv = s.b >> sh;
      2'd2: shv = (s.b >> sh) | (s.b[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
      default: shv = (sh == 5'd0) ? s.b : ((s.b >> sh) | (s.b << (6'd32 - {1'b0, sh})));
    endcase
`ifndef EX_OVERFLOW_TRAP_EN
    ov = 1'b0;
`endif
    if (s.shsel) ov = 1'b0;
    wreg = s.regdst ? s.rd : s.rt;
    wen = (wreg != 5'd0) && (s.dt0 ? (s.b == 32'd0) : (s.cond == 3'd0 && !s.jump));
    r.res = s.shsel ? shv : alu;
    r.wdata = s.b;
    r.wreg = wreg;
    r.wen = s.valid && wen && !ov;
    r.valid = s.valid;
    r.ovf = s.valid && ov;
    return r;
  endfunction

  function automatic logic f_redir(input stim_t s);
    logic t;
    case (s.cond)
      3'd1: t = s.a == s.b;
      3'd2: t = s.a != s.b;
      3'd3: t = s.a[31];
      3'd4: t = !s.a[31];
      3'd5: t = !s.a[31] && s.a != 32'd0;
      3'd6: t = s.a[31] || s.a == 32'd0;
      default: t = 1'b0;
    endcase
    return s.valid && !s.stall && (s.jump || t);
  endfunction

  function automatic logic [31:0] f_target(input stim_t s);
    return s.jump ? {s.pc4[31:28], s.off[25:0], 2'b00} : s.pc4 + (s.off << 2);
  endfunction

  task automatic drive(input stim_t s, input logic r);
    lat_t e;
    @(negedge clk);
    rst = r;
    bus.Rs_in = s.rs; bus.Rt_in = s.rt; bus.Rd_in = s.rd;
    bus.A_in = s.a; bus.B_in = s.b; bus.offset_in = s.off; bus.pc4_in = s.pc4;
    bus.RegDst_in = s.regdst; bus.Shift_amountSrc_in = s.shsrc; bus.Jump_in = s.jump;
    bus.ALUShift_Sel_in = s.shsel; bus.RegDt0_in = s.dt0;
    bus.ALU_op_in = s.aop; bus.Shift_op_in = s.sop; bus.ALUSrcB_in = s.srcb; bus.Condition_in = s.cond;
    bus.valid_in = s.valid; bus.stall_in = s.stall;
    e = r ? lat_t'('0) : (s.stall ? last : f_model(s));
    sb.push_back(e);
    last = e;
    #1;
  endtask

  always @(posedge clk) begin
    lat_t e, got;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      got = {bus.res_out, bus.wdata_out, bus.wreg_out, bus.wen_out, bus.valid_out, bus.ovf_out};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL latch: got res=%h wdata=%h wreg=%0d wen=%b valid=%b ovf=%b, want res=%h wdata=%h wreg=%0d wen=%b valid=%b ovf=%b",
                 got.res, got.wdata, got.wreg, got.wen, got.valid, got.ovf,
                 e.res, e.wdata, e.wreg, e.wen, e.valid, e.ovf);
      end
    end
  end

  task automatic test_reset();
    stim_t s = '0;
    s.valid = 1'b1; s.jump = 1'b1; s.rd = 5'd9; s.regdst = 1'b1; s.a = 32'd3;
    for (int i = 0; i < 2; i++) begin
      drive(s, 1'b1);
      checks++;
      if (bus.redirect !== 1'b0 || bus.flush_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_redirect: got redirect=%b flush=%b, want 0 0", bus.redirect, bus.flush_out);
      end
    end
  endtask

  task automatic test_add();
    stim_t s = '0;
    s.valid = 1'b1; s.a = 32'd7; s.b = 32'd5; s.regdst = 1'b1; s.rd = 5'd3; s.rt = 5'd8;
    drive(s, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (bus.res_out !== 32'd12 || bus.wreg_out !== 5'd3 || bus.wen_out !== 1'b1 || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL add: got res=%0d wreg=%0d wen=%b valid=%b, want 12 3 1 1",
               bus.res_out, bus.wreg_out, bus.wen_out, bus.valid_out);
    end
  endtask

  task automatic test_branch();
    stim_t s = '0;
    s.valid = 1'b1; s.cond = 3'd1; s.a = 32'd9; s.b = 32'd9; s.pc4 = 32'h100; s.off = 32'd4; s.rt = 5'd5;
    drive(s, 1'b0);
    checks++;
    if (bus.redirect !== 1'b1 || bus.flush_out !== 1'b1 || bus.target !== 32'h110) begin
      errors++;
      $display("FAIL beq: got redirect=%b flush=%b target=%h, want 1 1 00000110", bus.redirect, bus.flush_out, bus.target);
    end
    @(posedge clk); #2;
    checks++;
    if (bus.wen_out !== 1'b0 || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL beq_latch: got wen=%b valid=%b, want 0 1", bus.wen_out, bus.valid_out);
    end
    s.b = 32'd8; s.jump = 1'b1; s.pc4 = 32'hA0000004; s.off = 32'h0123456;
    drive(s, 1'b0);
    checks++;
    if (bus.redirect !== 1'b1 || bus.target !== 32'hA048D158) begin
      errors++;
      $display("FAIL jump: got redirect=%b target=%h, want 1 a048d158", bus.redirect, bus.target);
    end
    s = '0; s.valid = 1'b1; s.cond = 3'd2; s.a = 32'd4; s.b = 32'd4;
    drive(s, 1'b0);
    checks++;
    if (bus.redirect !== 1'b0) begin
      errors++;
      $display("FAIL bne_not_taken: got redirect=%b, want 0", bus.redirect);
    end
  endtask

  task automatic test_stall();
    stim_t s = '0;
    s.valid = 1'b1; s.aop = 4'd1; s.a = 32'd20; s.b = 32'd6; s.regdst = 1'b1; s.rd = 5'd4;
    drive(s, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s = '0;
      s.valid = 1'b1; s.stall = 1'b1; s.jump = 1'b1; s.a = 32'(100 + i); s.b = 32'd1; s.rd = 5'd7; s.regdst = 1'b1;
      drive(s, 1'b0);
      checks++;
      if (bus.redirect !== 1'b0 || bus.flush_out !== 1'b0) begin
        errors++;
        $display("FAIL stall_redirect: got redirect=%b flush=%b, want 0 0", bus.redirect, bus.flush_out);
      end
      @(posedge clk); #2;
      checks++;
      if (bus.res_out !== 32'd14 || bus.wreg_out !== 5'd4 || bus.wen_out !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: got res=%0d wreg=%0d wen=%b, want 14 4 1", bus.res_out, bus.wreg_out, bus.wen_out);
      end
    end
  endtask

  task automatic test_shift_and_edges();
    stim_t s = '0;
    s.valid = 1'b1; s.shsel = 1'b1; s.sop = 2'd2; s.b = 32'h80000000; s.off = 32'd4 << 6; s.rt = 5'd2;
    drive(s, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (bus.res_out !== 32'hF8000000) begin
      errors++;
      $display("FAIL sra: got res=%h, want f8000000", bus.res_out);
    end
    s.sop = 2'd3; s.shsrc = 1'b1; s.a = 32'd8; s.b = 32'h12345678;
    drive(s, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (bus.res_out !== 32'h78123456) begin
      errors++;
      $display("FAIL ror: got res=%h, want 78123456", bus.res_out);
    end
    s = '0; s.valid = 1'b1; s.a = 32'd1; s.b = 32'd2; s.rt = 5'd0;
    drive(s, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (bus.wen_out !== 1'b0) begin
      errors++;
      $display("FAIL reg0: got wen=%b, want 0", bus.wen_out);
    end
    s.dt0 = 1'b1; s.rt = 5'd6; s.b = 32'd0;
    drive(s, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (bus.wen_out !== 1'b1) begin
      errors++;
      $display("FAIL movz_zero: got wen=%b, want 1", bus.wen_out);
    end
    s.b = 32'd5;
    drive(s, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (bus.wen_out !== 1'b0) begin
      errors++;
      $display("FAIL movz_nonzero: got wen=%b, want 0", bus.wen_out);
    end
    s = '0; s.valid = 1'b0; s.a = 32'd3; s.rt = 5'd9; s.jump = 1'b1;
    drive(s, 1'b0);
    checks++;
    if (bus.redirect !== 1'b0) begin
      errors++;
      $display("FAIL bubble_redirect: got redirect=%b, want 0", bus.redirect);
    end
    @(posedge clk); #2;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.wen_out !== 1'b0) begin
      errors++;
      $display("FAIL bubble: got valid=%b wen=%b, want 0 0", bus.valid_out, bus.wen_out);
    end
  endtask

  task automatic test_overflow();
    stim_t s = '0;
    s.valid = 1'b1; s.a = 32'h7FFFFFFF; s.b = 32'd1; s.regdst = 1'b1; s.rd = 5'd10;
    drive(s, 1'b0);
    @(posedge clk); #2;
    checks++;
`ifdef EX_OVERFLOW_TRAP_EN
    if (bus.ovf_out !== 1'b1 || bus.wen_out !== 1'b0 || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got ovf=%b wen=%b valid=%b, want 1 0 1", bus.ovf_out, bus.wen_out, bus.valid_out);
    end
`else
    if (bus.res_out !== 32'h80000000 || bus.wen_out !== 1'b1 || bus.ovf_out !== 1'b0) begin
      errors++;
      $display("FAIL overflow: got res=%h wen=%b ovf=%b, want 80000000 1 0", bus.res_out, bus.wen_out, bus.ovf_out);
    end
`endif
  endtask

  task automatic test_back_to_back();
    stim_t s;
    for (int i = 0; i < 60; i++) begin
      s = '0;
      s.rs = 5'($urandom); s.rt = 5'($urandom); s.rd = 5'($urandom);
      s.a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      s.b = ($urandom_range(0, 3) == 0) ? s.a : $urandom;
      s.off = $urandom; s.pc4 = $urandom;
      s.regdst = 1'($urandom); s.shsrc = 1'($urandom); s.shsel = 1'($urandom);
      s.jump = ($urandom_range(0, 5) == 0); s.dt0 = ($urandom_range(0, 5) == 0);
      s.aop = 4'($urandom); s.sop = 2'($urandom); s.srcb = 3'($urandom);
      s.cond = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
      s.valid = ($urandom_range(0, 5) != 0); s.stall = ($urandom_range(0, 4) == 0);
      drive(s, 1'b0);
      checks++;
      if (bus.redirect !== f_redir(s) || bus.flush_out !== f_redir(s) || (f_redir(s) && bus.target !== f_target(s))) begin
        errors++;
        $display("FAIL b2b_redirect: got redirect=%b flush=%b target=%h, want %b %b %h",
                 bus.redirect, bus.flush_out, bus.target, f_redir(s), f_redir(s), f_target(s));
      end
    end
  endtask

  task automatic test_reset_stall();
    stim_t s = '0;
    s.valid = 1'b1; s.a = 32'd50; s.b = 32'd1; s.rt = 5'd12;
    drive(s, 1'b0);
    s.stall = 1'b1; s.jump = 1'b1;
    drive(s, 1'b1);
    @(posedge clk); #2;
    checks++;
    if (bus.res_out !== 32'd0 || bus.wdata_out !== 32'd0 || bus.wreg_out !== 5'd0 ||
        bus.wen_out !== 1'b0 || bus.valid_out !== 1'b0 || bus.ovf_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_stall: got res=%h wdata=%h wreg=%0d wen=%b valid=%b ovf=%b, want all 0",
               bus.res_out, bus.wdata_out, bus.wreg_out, bus.wen_out, bus.valid_out, bus.ovf_out);
    end
    s = '0;
    drive(s, 1'b0);
  endtask

  initial begin
    bus.Rs_in = '0; bus.Rt_in = '0; bus.Rd_in = '0; bus.A_in = '0; bus.B_in = '0;
    bus.offset_in = '0; bus.pc4_in = '0; bus.RegDst_in = 1'b0; bus.Shift_amountSrc_in = 1'b0;
    bus.Jump_in = 1'b0; bus.ALUShift_Sel_in = 1'b0; bus.RegDt0_in = 1'b0; bus.ALU_op_in = '0;
    bus.Shift_op_in = '0; bus.ALUSrcB_in = '0; bus.Condition_in = '0; bus.valid_in = 1'b0; bus.stall_in = 1'b0;
    test_reset();
    test_add();
    test_branch();
    test_stall();
    test_shift_and_edges();
    test_overflow();
    test_back_to_back();
    test_reset_stall();
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
